arbitro_vc: RTL and testbench

Two-requester scheduler between the virtual-channel FIFOs (VC0 high priority, VC1 low priority) and the four destination FIFOs D0-D3.
- Pops one word per cycle from the winning VC.
- Routes the word by its destination field and pushes it into the matching D FIFO one cycle later.
- Honours D-FIFO almost-full backpressure and the active state of the control FSM.
- Bounded-starvation counter guarantees VC1 service.

---
 rtl/arbitro_vc.sv | 107 ++++++++++
 tb/tb_arbitro_vc.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_vc.sv
// Two-VC scheduler feeding four destination FIFOs. VC0 has priority, and a
// saturating counter bounds how long a non-empty VC1 can be passed over.
module arbitro_vc #(
  parameter int DATA_W     = 6,
  parameter int DEST_LSB   = 4,
  parameter int MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active_in,
  input  logic              vc0_empty,
  input  logic              vc1_empty,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic [3:0]        d_almost_full,
  output logic              vc0_pop,
  output logic              vc1_pop,
  output logic [3:0]        d_push,
  output logic [DATA_W-1:0] d_data,
  output logic [1:0]        grant,
  output logic [3:0]        consec,
  output logic              arb_idle
);

  localparam logic [3:0] MAX_C = 4'(MAX_CONSEC);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SERV0 = 2'b01,
    SERV1 = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        consec_q, consec_d;
  logic [3:0]        d_push_q, d_push_d;
  logic [DATA_W-1:0] d_data_q, d_data_d;
  logic [1:0]        dest0, dest1;
  logic              elig0, elig1;
  logic              gnt0, gnt1;

  // Each head is judged only against its own destination's backpressure.
  assign dest0 = vc0_data[DEST_LSB +: 2];
  assign dest1 = vc1_data[DEST_LSB +: 2];
  assign elig0 = !vc0_empty && !d_almost_full[dest0];
  assign elig1 = !vc1_empty && !d_almost_full[dest1];

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (active_in) begin
      if (elig0 && elig1) begin
        if (consec_q == MAX_C) gnt1 = 1'b1;
        else                   gnt0 = 1'b1;
      end else if (elig0) begin
        gnt0 = 1'b1;
      end else if (elig1) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign vc0_pop = gnt0 && reset;
  assign vc1_pop = gnt1 && reset;

  always_comb begin
    state_d  = IDLE;
    d_push_d = 4'b0000;
    d_data_d = d_data_q;
    consec_d = consec_q;
    if (gnt0) begin
      state_d  = SERV0;
      d_push_d = 4'b0001 << dest0;
      d_data_d = vc0_data;
    end else if (gnt1) begin
      state_d  = SERV1;
      d_push_d = 4'b0001 << dest1;
      d_data_d = vc1_data;
    end
    // Counter only tracks VC0 wins while VC1 is actually waiting.
    if (gnt1 || vc1_empty) begin
      consec_d = 4'd0;
    end else if (gnt0 && (consec_q != MAX_C)) begin
      consec_d = consec_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      consec_q <= 4'd0;
      d_push_q <= 4'b0000;
      d_data_q <= '0;
    end else begin
      state_q  <= state_d;
      consec_q <= consec_d;
      d_push_q <= d_push_d;
      d_data_q <= d_data_d;
    end
  end

  assign d_push   = d_push_q;
  assign d_data   = d_data_q;
  assign grant    = state_q;
  assign consec   = consec_q;
  assign arb_idle = vc0_empty && vc1_empty && (d_push_q == 4'b0000);

endmodule

// File: tb/tb_arbitro_vc.sv
// Bench for arbitro_vc: vector table, directed sequences and random traffic
// checked against a queue-based reference model.
module tb_arbitro_vc;
  localparam int DATA_W = 6, DEST_LSB = 4, MAX_CONSEC = 4;

  logic clk = 1'b0, reset = 1'b0, active_in = 1'b0;
  logic vc0_empty = 1'b1, vc1_empty = 1'b1;
  logic [DATA_W-1:0] vc0_data = '0, vc1_data = '0;
  logic [3:0] d_almost_full = 4'b0;
  logic vc0_pop, vc1_pop, arb_idle;
  logic [3:0] d_push, consec;
  logic [DATA_W-1:0] d_data;
  logic [1:0] grant;

  arbitro_vc #(.DATA_W(DATA_W), .DEST_LSB(DEST_LSB), .MAX_CONSEC(MAX_CONSEC)) dut (
    .clk(clk), .reset(reset), .active_in(active_in),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .d_almost_full(d_almost_full),
    .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
    .d_push(d_push), .d_data(d_data), .grant(grant),
    .consec(consec), .arb_idle(arb_idle)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [DATA_W-1:0] q0[$], q1[$];
  int consec_m, streak, pushed_words, popped_words;
  logic [3:0] exp_push, af_prev;
  logic [DATA_W-1:0] exp_data;
  logic [1:0] exp_grant;

  typedef struct {
    logic act; logic e0; logic e1;
    logic [5:0] w0; logic [5:0] w1; logic [3:0] af;
    logic p0; logic p1; logic [3:0] push; logic [5:0] data; logic [3:0] cns;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int dest_of(input logic [DATA_W-1:0] w);
    return (int'(w) >> DEST_LSB) % 4;
  endfunction

  task automatic do_reset();
    reset = 1'b0; active_in = 1'b1; d_almost_full = 4'b0;
    vc0_empty = 1'b0; vc1_empty = 1'b0; vc0_data = 6'h05; vc1_data = 6'h16;
    repeat (2) begin
      #1;
      chk("rst_vc0_pop", vc0_pop, 0);
      chk("rst_vc1_pop", vc1_pop, 0);
      @(negedge clk);
    end
    chk("rst_d_push", d_push, 0);
    chk("rst_d_data", d_data, 0);
    chk("rst_grant", grant, 0);
    chk("rst_consec", consec, 0);
    q0.delete(); q1.delete();
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    #1;
    chk("rst_arb_idle", arb_idle, 1);
    reset = 1'b1;
    consec_m = 0; streak = 0; exp_push = 0; exp_data = 0; exp_grant = 0;
    pushed_words = 0; popped_words = 0;
  endtask

  // One cycle: present queue heads, compare pops against the model's choice,
  // advance the model, then compare the registered outputs after the edge.
  task automatic step(input logic act, input logic [3:0] af, output int dec);
    int e0, e1;
    logic [DATA_W-1:0] w;
    w = '0;
    active_in = act; d_almost_full = af;
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
    vc0_data = vc0_empty ? DATA_W'($urandom) : q0[0];
    vc1_data = vc1_empty ? DATA_W'($urandom) : q1[0];
    #1;
    e0 = (!vc0_empty && !af[dest_of(vc0_data)]) ? 1 : 0;
    e1 = (!vc1_empty && !af[dest_of(vc1_data)]) ? 1 : 0;
    dec = 0;
    if (act) begin
      if (e0 == 1 && e1 == 1) dec = (consec_m == MAX_CONSEC) ? 2 : 1;
      else if (e0 == 1) dec = 1;
      else if (e1 == 1) dec = 2;
    end
    chk("vc0_pop", vc0_pop, (dec == 1) ? 1 : 0);
    chk("vc1_pop", vc1_pop, (dec == 2) ? 1 : 0);
    chk("arb_idle", arb_idle, (vc0_empty && vc1_empty && exp_push == 0) ? 1 : 0);
    if (dec == 1 && e1 == 1) begin
      streak++;
      chk("vc1_wait_bound", (streak <= MAX_CONSEC) ? 1 : 0, 1);
    end
    if (dec == 2 || vc1_empty) streak = 0;
    if (dec == 1) w = q0.pop_front();
    else if (dec == 2) w = q1.pop_front();
    if (dec != 0) begin
      exp_push = 4'(1 << dest_of(w));
      exp_data = w;
      popped_words++;
    end else begin
      exp_push = 4'b0;
    end
    exp_grant = 2'(dec);
    if (dec == 2 || vc1_empty) consec_m = 0;
    else if (dec == 1) consec_m = (consec_m + 1 > MAX_CONSEC) ? MAX_CONSEC : consec_m + 1;
    af_prev = af;
    @(negedge clk);
    chk("d_push", d_push, exp_push);
    chk("d_data", d_data, exp_data);
    chk("grant", grant, exp_grant);
    chk("consec", consec, consec_m);
    if (d_push != 0) begin
      pushed_words += $countones(d_push);
      chk("push_onehot", $countones(d_push), 1);
      chk("push_vs_af", ((d_push & af_prev) == 0) ? 1 : 0, 1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int dec;
    int seq_dec[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    int seq_cns[10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    logic [5:0] t2_words[4] = '{6'h03, 6'h11, 6'h2A, 6'h35};

    //            act  e0   e1   w0     w1     af       p0   p1   push     data   cns
    vecs[0] = '{1'b0, 1'b1, 1'b1, 6'h1A, 6'h25, 4'b0000, 1'b0, 1'b0, 4'b0000, 6'h00, 4'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 6'h1A, 6'h25, 4'b0000, 1'b1, 1'b0, 4'b0010, 6'h1A, 4'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 6'h1A, 6'h25, 4'b0000, 1'b0, 1'b1, 4'b0100, 6'h25, 4'd0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 6'h1A, 6'h25, 4'b0000, 1'b1, 1'b0, 4'b0010, 6'h1A, 4'd1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 6'h1A, 6'h25, 4'b0010, 1'b0, 1'b1, 4'b0100, 6'h25, 4'd0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 6'h1A, 6'h25, 4'b0100, 1'b1, 1'b0, 4'b0010, 6'h1A, 4'd1};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 6'h1A, 6'h25, 4'b0110, 1'b0, 1'b0, 4'b0000, 6'h00, 4'd0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 6'h3F, 6'h25, 4'b1000, 1'b0, 1'b0, 4'b0000, 6'h00, 4'd0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 6'h0C, 6'h25, 4'b1110, 1'b1, 1'b0, 4'b0001, 6'h0C, 4'd0};

    for (int i = 0; i < 9; i++) begin
      do_reset();
      active_in = vecs[i].act; d_almost_full = vecs[i].af;
      vc0_empty = !vecs[i].e0; vc1_empty = !vecs[i].e1;
      vc0_data = vecs[i].w0; vc1_data = vecs[i].w1;
      #1;
      chk($sformatf("vec%0d_vc0_pop", i), vc0_pop, vecs[i].p0);
      chk($sformatf("vec%0d_vc1_pop", i), vc1_pop, vecs[i].p1);
      @(negedge clk);
      chk($sformatf("vec%0d_d_push", i), d_push, vecs[i].push);
      chk($sformatf("vec%0d_d_data", i), d_data, vecs[i].data);
      chk($sformatf("vec%0d_consec", i), consec, vecs[i].cns);
      $display("vec %0d: pops=%b%b d_push=%b d_data=%h consec=%0d",
               i, vc1_pop, vc0_pop, d_push, d_data, consec);
    end

    // VC0 only, one word per destination.
    do_reset();
    for (int i = 0; i < 4; i++) q0.push_back(t2_words[i]);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'b0000, dec);
      chk("t2_dec", dec, 1);
      chk("t2_d_push", d_push, 1 << i);
      chk("t2_d_data", d_data, t2_words[i]);
      chk("t2_consec", consec, 0);
      $display("t2 cycle %0d: d_push=%b d_data=%h", i, d_push, d_data);
    end

    // Both VCs loaded: VC1 gets every fifth slot.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      q0.push_back(6'($urandom));
      q1.push_back(6'($urandom));
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'b0000, dec);
      chk("t3_dec", dec, seq_dec[i]);
      chk("t3_consec", consec, seq_cns[i]);
      $display("t3 cycle %0d: grant=%b consec=%0d", i, grant, consec);
    end

    // VC0 blocked by backpressure must not hold up VC1.
    do_reset();
    q0.push_back(6'h2B);
    q1.push_back(6'h11); q1.push_back(6'h12); q1.push_back(6'h13);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0100, dec);
      chk("t4_blocked_dec", dec, 2);
      $display("t4 cycle %0d: grant=%b d_push=%b", i, grant, d_push);
    end
    step(1'b1, 4'b0000, dec);
    chk("t4_release_dec", dec, 1);
    chk("t4_release_push", d_push, 4'b0100);
    $display("t4 release: grant=%b d_push=%b", grant, d_push);

    // active_in drops right after a grant; the popped word still lands.
    do_reset();
    q0.push_back(6'h01); q0.push_back(6'h12); q0.push_back(6'h23); q0.push_back(6'h34);
    step(1'b1, 4'b0000, dec);
    chk("t5_first_dec", dec, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0000, dec);
      chk("t5_paused_dec", dec, 0);
      chk("t5_paused_push", d_push, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0000, dec);
      chk("t5_resume_dec", dec, 1);
    end
    chk("t5_words_pushed", pushed_words, 4);
    chk("t5_queue_drained", q0.size(), 0);
    $display("t5: pushed=%0d popped=%0d", pushed_words, popped_words);

    // Random traffic with random backpressure and activity.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) != 0 && q0.size() < 8) q0.push_back(6'($urandom));
      if ($urandom_range(0, 3) != 0 && q1.size() < 8) q1.push_back(6'($urandom));
      step($urandom_range(0, 9) != 0, 4'($urandom & $urandom), dec);
    end
    for (int c = 0; c < 100 && (q0.size() != 0 || q1.size() != 0); c++)
      step(1'b1, 4'b0000, dec);
    chk("rand_drained", q0.size() + q1.size(), 0);
    chk("rand_no_loss", pushed_words, popped_words);
    $display("random: pushed=%0d popped=%0d", pushed_words, popped_words);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
